rr_arbiter_4: RTL
=================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum number of consecutive cycles one grant may be held; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port req, input, 4 bits: request lines; bit i high means requester i wants service.
REQ-005 The block SHALL have port ack, input, 1 bit: the granted requester has finished and releases its grant.
REQ-006 The block SHALL have port gnt, output, 4 bits: registered grant; either all-zero or exactly one bit high (one-hot, for direct connection to the team's 4-to-2 encoder d input).
REQ-007 The block SHALL have port busy, output, 1 bit: high exactly when gnt is non-zero.
REQ-008 The block SHALL have port expired, output, 1 bit: registered one-cycle pulse flagging a grant forcibly released by the hold limit.

Function
REQ-009 The block SHALL implement two states: IDLE (gnt=0) and GRANT (gnt one-hot, held constant).
REQ-010 The block SHALL keep an internal 2-bit pointer last, the index of the most recently released grant.
REQ-011 In IDLE, if req is non-zero at a rising edge, the block SHALL select the first set bit scanning upward from (last+1) mod 4 with wrap-around, load gnt with that one-hot value, clear hold_cnt to 0 and enter GRANT.
REQ-012 In IDLE with req=0, the block SHALL remain in IDLE with gnt=0; ack SHALL be ignored in IDLE.
REQ-013 Grant latency SHALL be exactly one cycle: req sampled at edge n gives gnt valid after edge n.
REQ-014 In GRANT, the release condition SHALL be: ack=1, OR req[granted index]=0, OR hold_cnt=MAX_HOLD-1.
REQ-015 On a release edge the block SHALL clear gnt to 0, set last to the granted index and enter IDLE, giving at least one idle (gnt=0) cycle between successive grants.
REQ-016 On a non-release edge in GRANT, hold_cnt SHALL increment by 1 and gnt SHALL remain unchanged; hold_cnt is 8 bits wide and never wraps, since release occurs at MAX_HOLD-1.
REQ-017 A grant with no early release SHALL therefore remain visible for exactly MAX_HOLD cycles.
REQ-018 expired SHALL be set to 1 for one cycle after a release edge only when hold_cnt=MAX_HOLD-1, ack=0 and req[granted index]=1; otherwise it SHALL be 0.
REQ-019 Simultaneous ack and hold-limit SHALL release with expired=0 (ack takes precedence).
REQ-020 Changes to req bits other than the granted one during GRANT SHALL have no effect until the next IDLE evaluation.
REQ-021 gnt SHALL never have more than one bit set, in any cycle.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL force state=IDLE, gnt=4'b0000, busy=0, expired=0, hold_cnt=0 and last=3, so that requester 0 has first priority after reset.
REQ-023 rst SHALL override all other inputs, including during GRANT (mid-grant reset drops gnt to 0 at that edge, with no expired pulse).

Verification
REQ-024 Reset then req=4'b1111 held and ack pulsed 1 cycle after each grant: gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-025 MAX_HOLD=8, req=4'b0100 held, ack=0: gnt=0100 for exactly 8 cycles, then gnt=0000 with expired=1 for one cycle, then gnt=0100 again.
REQ-026 Grant on 0010, then req[1] dropped with ack=0 while req=4'b1001: next gnt is 1000 (pointer wrap from 1 scans 2,3), and expired stays 0.
REQ-027 ack=1 at the same edge as hold_cnt=MAX_HOLD-1: release occurs with expired=0.
REQ-028 rst=1 asserted during GRANT on 1000: gnt=0000 next cycle; then req=4'b1001 gives gnt=0001 (pointer reset to 3).
REQ-029 Random req/ack over 10k cycles: check that gnt is one-hot or zero in every cycle, busy equals |gnt, and no grant lasts more than MAX_HOLD cycles.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a per-grant hold limit.
// One idle cycle separates successive grants; forced releases pulse expired.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       expired
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_idx;
    logic [1:0] r_last;
    logic [7:0] r_hold;
    logic       r_expired;

    logic [1:0] w_sel;
    logic       w_at_limit;
    logic       w_req_held;
    logic       w_release;

    // Lowest offset from last+1 wins, so scan offsets downward.
    always_comb begin
        w_sel = r_last + 2'd1;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_last + 2'(k + 1)]) begin
                w_sel = r_last + 2'(k + 1);
            end
        end
    end

    assign w_at_limit = (r_hold == HOLD_LAST);
    assign w_req_held = req[r_idx];
    assign w_release  = ack || !w_req_held || w_at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= 4'b0000;
            r_idx     <= 2'd0;
            r_last    <= 2'd3;
            r_hold    <= 8'd0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt   <= 4'b0001 << w_sel;
                        r_idx   <= w_sel;
                        r_hold  <= 8'd0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_gnt     <= 4'b0000;
                        r_last    <= r_idx;
                        r_state   <= S_IDLE;
                        r_expired <= w_at_limit && !ack && w_req_held;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = |r_gnt;
    assign expired = r_expired;

endmodule
